// File: rtl/sdram_arbiter.sv
// Round-robin arbiter that shares one SDRAM controller user interface among
// NUM_PORTS requesters. It holds one command until the controller accepts it,
// routes read responses back to the issuing port, and answers a read that never
// returns with an error response once the watchdog expires.
module sdram_arbiter #(
  parameter int NUM_PORTS      = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_PORTS-1:0]    req_valid,
  input  logic [NUM_PORTS-1:0]    req_rw,
  input  logic [23*NUM_PORTS-1:0] req_addr,
  input  logic [32*NUM_PORTS-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]    req_ready,
  output logic [NUM_PORTS-1:0]    resp_valid,
  output logic [31:0]             resp_rdata,
  output logic                    resp_err,
  output logic [22:0]             mc_addr,
  output logic                    mc_rw,
  output logic [31:0]             mc_data_in,
  output logic                    mc_in_valid,
  input  logic [31:0]             mc_data_out,
  input  logic                    mc_out_valid,
  input  logic                    mc_busy
);

  localparam int PW = (NUM_PORTS > 2) ? 2 : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } state_t;

  state_t          state_reg;
  logic [PW-1:0]   owner_reg;
  logic [PW-1:0]   last_grant_reg;
  logic [15:0]     cnt_reg;
  logic [PW-1:0]   winner;
  logic [16:0]     cnt_inc;
  logic            timeout_hit;

  logic [22:0] addr_a  [NUM_PORTS];
  logic [31:0] wdata_a [NUM_PORTS];

  // Split the flat per-port buses into indexable arrays.
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
    assign addr_a[gi]  = req_addr[23*gi +: 23];
    assign wdata_a[gi] = req_wdata[32*gi +: 32];
  end

  // Round-robin pick: scan from farthest to nearest so the port right after
  // last_grant overrides everything else when it is requesting.
  always_comb begin
    int idx;
    idx    = 0;
    winner = last_grant_reg;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      idx = (int'(last_grant_reg) + k) % NUM_PORTS;
      if (req_valid[idx]) winner = PW'(idx);
    end
  end

  // Watchdog: the expiring cycle is the one whose incremented count reaches the limit.
  assign cnt_inc     = {1'b0, cnt_reg} + 17'd1;
  assign timeout_hit = (cnt_inc >= 17'(TIMEOUT_CYCLES));

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      owner_reg      <= '0;
      last_grant_reg <= PW'(NUM_PORTS - 1);
      cnt_reg        <= '0;
      req_ready      <= '0;
      resp_valid     <= '0;
      resp_rdata     <= '0;
      resp_err       <= 1'b0;
      mc_addr        <= '0;
      mc_rw          <= 1'b0;
      mc_data_in     <= '0;
      mc_in_valid    <= 1'b0;
    end else begin
      req_ready  <= '0;
      resp_valid <= '0;
      unique case (state_reg)
        IDLE: begin
          // Skip the cycle where req_ready is still showing, so the port just
          // served cannot be granted again on its stale request.
          if ((|req_valid) && (req_ready == '0)) begin
            mc_addr        <= addr_a[winner];
            mc_rw          <= req_rw[winner];
            mc_data_in     <= wdata_a[winner];
            mc_in_valid    <= 1'b1;
            owner_reg      <= winner;
            last_grant_reg <= winner;
            state_reg      <= ISSUE;
          end
        end
        ISSUE: begin
          if (mc_in_valid && !mc_busy) begin
            mc_in_valid          <= 1'b0;
            req_ready[owner_reg] <= 1'b1;
            cnt_reg              <= '0;
            state_reg            <= mc_rw ? IDLE : WAIT_RD;
          end
        end
        WAIT_RD: begin
          if (cnt_reg != 16'hFFFF) cnt_reg <= cnt_reg + 16'd1;
          if (mc_out_valid) begin
            resp_rdata            <= mc_data_out;
            resp_err              <= 1'b0;
            resp_valid[owner_reg] <= 1'b1;
            state_reg             <= IDLE;
          end else if (timeout_hit) begin
            resp_rdata            <= '0;
            resp_err              <= 1'b1;
            resp_valid[owner_reg] <= 1'b1;
            state_reg             <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: a cycle table for a write and a read, then
// hand-written sequences for fairness, busy stall, timeout and mid-read reset.
module tb_sdram_arbiter;

  localparam int TO = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_rw, req_ready, resp_valid;
  logic [45:0] req_addr;
  logic [63:0] req_wdata;
  logic [31:0] resp_rdata, mc_data_in, mc_data_out;
  logic        resp_err, mc_rw, mc_in_valid, mc_out_valid, mc_busy;
  logic [22:0] mc_addr;

  int n_total = 0;
  int n_pass  = 0;

  sdram_arbiter #(.NUM_PORTS(2), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mc_addr(mc_addr), .mc_rw(mc_rw), .mc_data_in(mc_data_in), .mc_in_valid(mc_in_valid),
    .mc_data_out(mc_data_out), .mc_out_valid(mc_out_valid), .mc_busy(mc_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  rv, rw;
    logic        busy, ov;
    logic [31:0] dout;
    logic        e_miv;
    logic [1:0]  e_rdy, e_rsp;
    logic        e_err;
    logic [22:0] e_addr;
    logic        e_rw;
    logic [31:0] e_din, e_rdata;
  } vec_t;

  vec_t vec [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ngrant;
    logic [22:0] held_addr;
    logic [1:0]  exp_g;

    rst = 1'b1; req_valid = '0; req_rw = '0; mc_busy = 1'b0; mc_out_valid = 1'b0; mc_data_out = '0;
    req_addr  = {23'h7FFFFF, 23'h000010};
    req_wdata = {32'hCAFEF00D, 32'hDEADBEEF};

    // rv rw busy ov dout | miv rdy rsp err addr rw din rdata
    vec[0]  = '{2'b01, 2'b01, 1'b0, 1'b0, 32'h0, 1'b1, 2'b00, 2'b00, 1'b0, 23'h000010, 1'b1, 32'hDEADBEEF, 32'h0};
    vec[1]  = '{2'b01, 2'b01, 1'b0, 1'b0, 32'h0, 1'b0, 2'b01, 2'b00, 1'b0, 23'h000010, 1'b1, 32'hDEADBEEF, 32'h0};
    vec[2]  = '{2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 2'b00, 2'b00, 1'b0, 23'h000010, 1'b1, 32'hDEADBEEF, 32'h0};
    vec[3]  = '{2'b10, 2'b00, 1'b0, 1'b0, 32'h0, 1'b1, 2'b00, 2'b00, 1'b0, 23'h7FFFFF, 1'b0, 32'hCAFEF00D, 32'h0};
    vec[4]  = '{2'b10, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 2'b10, 2'b00, 1'b0, 23'h7FFFFF, 1'b0, 32'hCAFEF00D, 32'h0};
    for (int i = 5; i <= 8; i++)
      vec[i] = '{2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 2'b00, 2'b00, 1'b0, 23'h7FFFFF, 1'b0, 32'hCAFEF00D, 32'h0};
    vec[9]  = '{2'b00, 2'b00, 1'b0, 1'b1, 32'h12345678, 1'b0, 2'b00, 2'b10, 1'b0, 23'h7FFFFF, 1'b0, 32'hCAFEF00D, 32'h12345678};
    vec[10] = '{2'b00, 2'b00, 1'b0, 1'b1, 32'hAAAAAAAA, 1'b0, 2'b00, 2'b00, 1'b0, 23'h7FFFFF, 1'b0, 32'hCAFEF00D, 32'h12345678};

    // Reset state
    tick(); tick();
    chk("rst_miv", 32'(mc_in_valid), 32'd0);
    chk("rst_rdy", 32'(req_ready), 32'd0);
    chk("rst_rsp", 32'(resp_valid), 32'd0);
    rst = 1'b0;
    $display("reset released");

    // Write on port 0, then read on port 1 answered 5 cycles after acceptance
    for (int i = 0; i < 11; i++) begin
      req_valid = vec[i].rv; req_rw = vec[i].rw; mc_busy = vec[i].busy;
      mc_out_valid = vec[i].ov; mc_data_out = vec[i].dout;
      tick();
      $display("vec %0d: miv=%b rdy=%b rsp=%b err=%b addr=%h rdata=%h", i, mc_in_valid, req_ready,
               resp_valid, resp_err, mc_addr, resp_rdata);
      chk($sformatf("v%0d_miv", i), 32'(mc_in_valid), 32'(vec[i].e_miv));
      chk($sformatf("v%0d_rdy", i), 32'(req_ready), 32'(vec[i].e_rdy));
      chk($sformatf("v%0d_rsp", i), 32'(resp_valid), 32'(vec[i].e_rsp));
      chk($sformatf("v%0d_err", i), 32'(resp_err), 32'(vec[i].e_err));
      chk($sformatf("v%0d_addr", i), 32'(mc_addr), 32'(vec[i].e_addr));
      chk($sformatf("v%0d_rw", i), 32'(mc_rw), 32'(vec[i].e_rw));
      chk($sformatf("v%0d_din", i), mc_data_in, vec[i].e_din);
      chk($sformatf("v%0d_rdata", i), resp_rdata, vec[i].e_rdata);
    end
    mc_out_valid = 1'b0;

    // Fairness: both ports write continuously; last grant was port 1
    req_valid = 2'b11; req_rw = 2'b11;
    ngrant = 0;
    for (int c = 0; c < 200 && ngrant < 8; c++) begin
      tick();
      if (req_ready != 2'b00) begin
        exp_g = (ngrant % 2 == 0) ? 2'b01 : 2'b10;
        $display("fair grant %0d: req_ready=%b", ngrant, req_ready);
        chk($sformatf("fair_grant%0d", ngrant), 32'(req_ready), 32'(exp_g));
        ngrant++;
      end
    end
    if (ngrant < 8) chk("fair_timeout", 32'(ngrant), 32'd8);
    req_valid = 2'b00;
    tick(); tick();

    // Busy stall on a port 0 write
    mc_busy = 1'b1; req_valid = 2'b01; req_rw = 2'b01;
    tick();
    held_addr = mc_addr;
    chk("busy_grant_addr", 32'(held_addr), 32'h000010);
    for (int c = 0; c < 10; c++) begin
      tick();
      $display("busy cycle %0d: miv=%b rdy=%b addr=%h", c, mc_in_valid, req_ready, mc_addr);
      chk($sformatf("busy%0d_miv", c), 32'(mc_in_valid), 32'd1);
      chk($sformatf("busy%0d_addr", c), 32'(mc_addr), 32'(held_addr));
      chk($sformatf("busy%0d_rdy", c), 32'(req_ready), 32'd0);
    end
    mc_busy = 1'b0;
    tick();
    chk("busy_accept_rdy", 32'(req_ready), 32'b01);
    chk("busy_accept_miv", 32'(mc_in_valid), 32'd0);
    req_valid = 2'b00;
    tick();
    chk("busy_single_rdy", 32'(req_ready), 32'd0);
    $display("busy stall done");

    // Timeout on a port 1 read
    req_valid = 2'b10; req_rw = 2'b00;
    tick();
    chk("to_miv", 32'(mc_in_valid), 32'd1);
    tick();
    chk("to_rdy", 32'(req_ready), 32'b10);
    req_valid = 2'b00;
    for (int c = 1; c < TO; c++) begin
      tick();
      chk($sformatf("to_quiet%0d", c), 32'(resp_valid), 32'd0);
    end
    tick();
    $display("timeout: rsp=%b err=%b rdata=%h", resp_valid, resp_err, resp_rdata);
    chk("to_rsp", 32'(resp_valid), 32'b10);
    chk("to_err", 32'(resp_err), 32'd1);
    chk("to_rdata", resp_rdata, 32'h0);
    mc_out_valid = 1'b1; mc_data_out = 32'h55555555;
    tick();
    chk("late_ov_ignored", 32'(resp_valid), 32'd0);
    mc_out_valid = 1'b0;
    req_valid = 2'b01; req_rw = 2'b01;
    tick();
    chk("after_to_miv", 32'(mc_in_valid), 32'd1);
    tick();
    chk("after_to_rdy", 32'(req_ready), 32'b01);
    req_valid = 2'b00;
    tick();

    // Reset asserted while a port 0 read waits for data
    req_valid = 2'b01; req_rw = 2'b00;
    tick(); tick();
    chk("rr_rdy", 32'(req_ready), 32'b01);
    req_valid = 2'b00;
    tick();
    #3 rst = 1'b1;
    #1;
    $display("mid-read reset: miv=%b addr=%h din=%h rdata=%h", mc_in_valid, mc_addr, mc_data_in, resp_rdata);
    chk("rr_addr0", 32'(mc_addr), 32'd0);
    chk("rr_din0", mc_data_in, 32'd0);
    chk("rr_rsp0", 32'(resp_valid), 32'd0);
    chk("rr_rdata0", resp_rdata, 32'd0);
    chk("rr_miv0", 32'(mc_in_valid), 32'd0);
    #7 rst = 1'b0;
    req_valid = 2'b11; req_rw = 2'b11;
    tick();
    chk("rr_win_miv", 32'(mc_in_valid), 32'd1);
    chk("rr_win_addr", 32'(mc_addr), 32'h000010);
    tick();
    chk("rr_win_rdy", 32'(req_ready), 32'b01);
    req_valid = 2'b00;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
